// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the five-stage RV64 pipeline: sequencer state
// encoding, the hard-wired zero register and the NOP used for bubbles.
package rv_pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_t;

  localparam logic [4:0]  REG_X0    = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0
  localparam int          FCNT_W    = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: decides advance/hold/flush for PC, IF/ID, ID/EX and
// EX/MEM/WB. Perf counters are built only when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_hold,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_memwait,
  output state_t            dbg_state,
  output logic [FCNT_W-1:0] dbg_fcnt
);

  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              mem_wait;
  logic              load_use;
  logic              stall_ev, flush_ev, wait_ev;

  // mem_req/mem_ready: a MEM access is outstanding while mem_req is high and
  // mem_ready low; it completes in the cycle both are high.
  assign mem_wait = mem_req && !mem_ready;
  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    wait_ev     = 1'b0;
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_wait) begin
      // EX is frozen, so a pending redirect or load-use is seen again later
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      wait_ev    = 1'b1;
    end else if (ex_redirect || (state_q == REDIR)) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_ev    = 1'b1;
      if (ex_redirect) begin
        if (FLUSH_CYCLES > 1) begin
          state_d = REDIR;
          fcnt_d  = FCNT_RELOAD;
        end
      end else if (fcnt_q == FCNT_W'(1)) begin
        state_d = RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q - FCNT_W'(1);
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_ev    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign dbg_state = state_q;
  assign dbg_fcnt  = fcnt_q;

`ifdef HAZARD_PERF_EN
  sat_counter #(.W(PERF_W)) u_cnt_stall (
    .clk(clk), .rst(rst), .inc(stall_ev), .count(perf_stall)
  );
  sat_counter #(.W(PERF_W)) u_cnt_flush (
    .clk(clk), .rst(rst), .inc(flush_ev), .count(perf_flush)
  );
  sat_counter #(.W(PERF_W)) u_cnt_memwait (
    .clk(clk), .rst(rst), .inc(wait_ev), .count(perf_memwait)
  );
`else
  logic unused_ev;
  assign unused_ev    = stall_ev ^ flush_ev ^ wait_ev;
  assign perf_stall   = '0;
  assign perf_flush   = '0;
  assign perf_memwait = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (FLUSH_CYCLES=3, PERF_W=4): directed scenarios
// then random traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  import rv_pipe_pkg::*;

  localparam int FC     = 3;
  localparam int PW     = 4;
  localparam int SATMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic          ex_mem_read = 1'b0, ex_redirect = 1'b0;
  logic          mem_req = 1'b0, mem_ready = 1'b1;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [PW-1:0] perf_stall, perf_flush, perf_memwait;
  state_t        dbg_state;
  logic [2:0]    dbg_fcnt;

  int total = 0;
  int bad   = 0;

  // model: flush cycles still owed after the current one, and event tallies
  int m_rem   = 0;
  int m_stall = 0;
  int m_flush = 0;
  int m_wait  = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_memwait(perf_memwait),
    .dbg_state(dbg_state), .dbg_fcnt(dbg_fcnt)
  );

  always #5 clk = ~clk;

  function automatic int exp_cnt(input int n);
`ifdef HAZARD_PERF_EN
    return (n > SATMAX) ? SATMAX : n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd3; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  // Called just after a negedge with inputs set: check outputs, then advance
  // the model across the next rising edge.
  task automatic tick(input string tag);
    logic e_pc, e_ifw, e_fl, e_bub, e_hold, luse, ev_s, ev_f, ev_w;
    #1;
    if (!rst) begin
      m_rem = 0; m_stall = 0; m_flush = 0; m_wait = 0;
    end
    luse = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    ev_s = 1'b0; ev_f = 1'b0; ev_w = 1'b0;
    if (!rst) begin
      {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00110;
    end else if (mem_req && !mem_ready) begin
      {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00001; ev_w = 1'b1;
    end else if (ex_redirect || m_rem > 0) begin
      {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b11110; ev_f = 1'b1;
    end else if (luse) begin
      {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00010; ev_s = 1'b1;
    end else begin
      {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b11000;
    end
    chk({tag, ".pc_write"},    32'(pc_write),    32'(e_pc));
    chk({tag, ".ifid_write"},  32'(ifid_write),  32'(e_ifw));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
    chk({tag, ".pipe_hold"},   32'(pipe_hold),   32'(e_hold));
    chk({tag, ".perf_stall"},  32'(perf_stall),  32'(exp_cnt(m_stall)));
    chk({tag, ".perf_flush"},  32'(perf_flush),  32'(exp_cnt(m_flush)));
    chk({tag, ".perf_memwait"},32'(perf_memwait),32'(exp_cnt(m_wait)));
    chk({tag, ".in_redirect"}, 32'(dbg_state == REDIR), 32'(m_rem > 0));
    @(posedge clk);
    if (rst) begin
      if (!ev_w) begin
        if (ex_redirect) m_rem = FC - 1;
        else if (m_rem > 0) m_rem--;
      end
      m_stall += int'(ev_s);
      m_flush += int'(ev_f);
      m_wait  += int'(ev_w);
    end
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    tick("reset0");
    tick("reset1");
    rst = 1'b1;
    tick("idle");

    // ld x5 in EX, addi x6,x5,1 in ID
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    tick("loaduse");
    ex_mem_read = 1'b0;
    tick("loaduse_after");

    // rs2 match also stalls
    set_idle(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    tick("loaduse_rs2");
    set_idle();

    // ld x0 with add reading x0: no stall
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    tick("ld_x0");
    // jal behind ld x5: reads nothing
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    tick("jal_no_use");
    set_idle();

    // redirect: three flush cycles then back to RUN
    ex_redirect = 1'b1;
    tick("redir0");
    ex_redirect = 1'b0;
    tick("redir1");
    tick("redir2");
    tick("redir_done");

    // redirect while memory waits 4 cycles, flush on release
    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) tick("memwait");
    mem_ready = 1'b1;
    tick("memwait_release");
    set_idle();
    tick("after_wait_f1");
    tick("after_wait_f2");
    tick("after_wait_run");

    // reset in the middle of a redirect (one flush cycle owed beyond current)
    ex_redirect = 1'b1;
    tick("pre_reset_redir");
    ex_redirect = 1'b0;
    rst = 1'b0;
    tick("mid_redir_reset");
    rst = 1'b1;
    tick("post_reset0");
    tick("post_reset1");

    // 20 load-use stalls to saturate the stall counter
    for (int i = 0; i < 20; i++) begin
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
      tick("sat_stall");
      set_idle();
      tick("sat_gap");
    end

    // random traffic, small register range so hazards occur often
    for (int i = 0; i < 400; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 7) == 0);
      mem_req     = 1'($urandom_range(0, 1));
      mem_ready   = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 59) != 0);
      tick("rand");
    end
    rst = 1'b1;
    set_idle();
    tick("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
